// File: rtl/spi_master_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_gen
//  Purpose  : Parametrised full-duplex SPI master with run-time CPOL/CPHA,
//             bit order and slave select, one word per valid/ready request.
//  Revision : 1.0  initial release
// ============================================================================
module spi_master_gen #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 4,
    parameter int NUM_SS   = 1,
    parameter int SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int HCW = $clog2(HALF_DIV);
    localparam int ECW = $clog2(2 * DATA_W);
    localparam logic [HCW-1:0] c_HALF_LAST = HCW'(HALF_DIV - 1);
    localparam logic [ECW-1:0] c_EDGE_LAST = ECW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [HCW-1:0]     r_hcnt;
    logic [ECW-1:0]     r_ecnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_sck;
    logic               r_mosi;
    logic [NUM_SS-1:0]  r_ss_n;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic [DATA_W-1:0]  r_tx_sh;
    logic [DATA_W-1:0]  r_rx_sh;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_lsb;
    logic               r_miso_s1;
    logic               r_miso_s2;

    logic               w_accept;
    logic               w_tick;
    logic               w_edge;
    logic [ECW-1:0]     w_eidx;
    logic               w_lead;
    logic               w_sample;
    logic               w_shift;
    logic [DATA_W-1:0]  w_rx_next;
    logic [NUM_SS-1:0]  w_ss_dec;

    function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic f_head(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    assign w_accept = tx_valid && r_ready;
    assign w_tick   = (r_hcnt == c_HALF_LAST);

    // w_eidx is the index of the sck edge produced on this clk edge, if any
    always_comb begin
        w_edge = 1'b0;
        w_eidx = '0;
        if (w_tick) begin
            if (r_state == S_SETUP) begin
                w_edge = 1'b1;
            end else if (r_state == S_XFER && r_ecnt != c_EDGE_LAST) begin
                w_edge = 1'b1;
                w_eidx = r_ecnt + 1'b1;
            end
        end
    end

    assign w_lead    = ~w_eidx[0];
    assign w_sample  = w_edge && (w_lead ^ r_cpha);
    assign w_shift   = w_edge && (r_cpha ? w_lead : (!w_lead && w_eidx != c_EDGE_LAST));
    assign w_rx_next = r_lsb ? {r_miso_s2, r_rx_sh[DATA_W-1:1]}
                             : {r_rx_sh[DATA_W-2:0], r_miso_s2};

    // Out-of-range selects decode to all ones
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            w_ss_dec[i] = (ss_sel != SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_hcnt     <= '0;
            r_ecnt     <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= '1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SETUP;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_hcnt  <= '0;
                        r_ecnt  <= '0;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_lsb   <= lsb_first;
                        r_sck   <= cpol;
                        r_ss_n  <= w_ss_dec;
                        r_rx_sh <= '0;
                        // Mode 0/2 present the first bit now; modes 1/3 on the first leading edge
                        r_tx_sh <= cpha ? tx_data : f_shift(tx_data, lsb_first);
                        r_mosi  <= cpha ? 1'b0 : f_head(tx_data, lsb_first);
                    end
                end
                S_SETUP: begin
                    if (w_tick) begin
                        r_state <= S_XFER;
                        r_hcnt  <= '0;
                        r_ecnt  <= '0;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_hcnt <= '0;
                        if (r_ecnt == c_EDGE_LAST) begin
                            r_state <= S_HOLD;
                            r_sck   <= r_cpol;
                        end else begin
                            r_ecnt <= w_eidx;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_state    <= S_IDLE;
                        r_hcnt     <= '0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_ss_n     <= '1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_edge) begin
                r_sck <= ~r_sck;
            end
            if (w_sample) begin
                r_rx_sh <= w_rx_next;
            end
            if (w_shift) begin
                r_mosi  <= f_head(r_tx_sh, r_lsb);
                r_tx_sh <= f_shift(r_tx_sh, r_lsb);
            end
        end
    end

    assign tx_ready = r_ready;
    assign busy     = r_busy;
    assign sck      = r_sck;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_gen
//  Purpose  : Directed, table-driven bench for spi_master_gen (8-bit/4-slave
//             and 16-bit/5-slave instances, behavioural slave on instance A).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        va, vb, d_cpol, d_cpha, d_lsb;
    logic [2:0]  d_sel;
    logic [15:0] d_tx;
    logic        loop_a, miso_a;

    logic        ua_tx_ready, ua_sck, ua_mosi, ua_rx_valid, ua_busy;
    logic [3:0]  ua_ss_n;
    logic [7:0]  ua_rx_data;
    logic        ub_tx_ready, ub_sck, ub_mosi, ub_rx_valid, ub_busy;
    logic [4:0]  ub_ss_n;
    logic [15:0] ub_rx_data;

    logic        s_cpol, s_cpha, s_lsb, s_miso, s_selq, s_sckq;
    logic [7:0]  s_word, s_rx;
    int          s_idx;

    assign miso_a = loop_a ? ua_mosi : s_miso;

    spi_master_gen #(.DATA_W(8), .HALF_DIV(4), .NUM_SS(4)) u_a (
        .clk(clk), .reset(rst_n), .tx_valid(va), .tx_ready(ua_tx_ready),
        .tx_data(d_tx[7:0]), .ss_sel(d_sel[1:0]), .cpol(d_cpol), .cpha(d_cpha),
        .lsb_first(d_lsb), .miso(miso_a), .sck(ua_sck), .mosi(ua_mosi),
        .ss_n(ua_ss_n), .rx_data(ua_rx_data), .rx_valid(ua_rx_valid), .busy(ua_busy)
    );

    spi_master_gen #(.DATA_W(16), .HALF_DIV(4), .NUM_SS(5)) u_b (
        .clk(clk), .reset(rst_n), .tx_valid(vb), .tx_ready(ub_tx_ready),
        .tx_data(d_tx), .ss_sel(d_sel), .cpol(d_cpol), .cpha(d_cpha),
        .lsb_first(d_lsb), .miso(ub_mosi), .sck(ub_sck), .mosi(ub_mosi),
        .ss_n(ub_ss_n), .rx_data(ub_rx_data), .rx_valid(ub_rx_valid), .busy(ub_busy)
    );

    // Shared view of whichever instance the current transfer uses
    logic        mb;
    logic        m_sck, m_mosi, m_rxv;
    logic [4:0]  m_ss;
    logic [15:0] m_rx;
    assign m_sck  = mb ? ub_sck : ua_sck;
    assign m_mosi = mb ? ub_mosi : ua_mosi;
    assign m_rxv  = mb ? ub_rx_valid : ua_rx_valid;
    assign m_ss   = mb ? ub_ss_n : {1'b1, ua_ss_n};
    assign m_rx   = mb ? ub_rx_data : {8'h00, ua_rx_data};

    // Behavioural SPI slave on instance A: drives s_word, captures s_rx
    always @(posedge clk) begin
        #1;
        if (ua_ss_n != 4'hf && !s_selq) begin
            s_rx  = 8'h00;
            s_idx = 0;
            if (!s_cpha) begin
                s_miso = s_lsb ? s_word[0] : s_word[7];
                s_idx  = 1;
            end
        end else if (ua_ss_n != 4'hf && ua_sck != s_sckq) begin
            if ((ua_sck != s_cpol) ^ s_cpha) begin
                s_rx = s_lsb ? {ua_mosi, s_rx[7:1]} : {s_rx[6:0], ua_mosi};
            end else if (s_idx < 8) begin
                s_miso = s_lsb ? s_word[s_idx] : s_word[7 - s_idx];
                s_idx  = s_idx + 1;
            end
        end
        s_selq = (ua_ss_n != 4'hf);
        s_sckq = ua_sck;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One request, then observe until rx_valid (bounded); inputs are scrambled after accept
    task automatic xfer(input logic use_b, input logic c_pol, input logic c_pha, input logic lsb,
                        input logic [2:0] sel, input logic [15:0] tx,
                        output int lat, output int togg, output int rises, output int ss_low,
                        output logic [4:0] mask, output logic [15:0] slots, output logic [15:0] rx);
        int   ns;
        logic prev;
        mb = use_b;
        s_cpol = c_pol; s_cpha = c_pha; s_lsb = lsb;
        d_cpol = c_pol; d_cpha = c_pha; d_lsb = lsb; d_sel = sel; d_tx = tx;
        if (use_b) vb = 1'b1; else va = 1'b1;
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0;
        d_tx = ~tx; d_cpol = ~c_pol; d_cpha = ~c_pha; d_lsb = ~lsb; d_sel = sel ^ 3'b001;
        lat = 0; togg = 0; rises = 0; ss_low = 0; mask = '0; slots = '0; ns = 0;
        prev = m_sck;
        if (m_ss != 5'h1f) ss_low++;
        mask |= ~m_ss;
        while (lat < 400 && !m_rxv) begin
            @(posedge clk); #1;
            lat++;
            if (m_sck != prev) begin
                togg++;
                if (m_sck) rises++;
                if (((m_sck != c_pol) ^ c_pha) && ns < 16) begin
                    slots[ns] = m_mosi;
                    ns++;
                end
            end
            prev = m_sck;
            if (m_ss != 5'h1f) ss_low++;
            mask |= ~m_ss;
        end
        rx = m_rx;
    endtask

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [2:0] sel;
        logic [7:0] tx, sw;
        logic       loop;
        logic [7:0] exp_rx;
        logic [3:0] exp_mask;
    } vec_t;

    initial begin
        vec_t        vt[4];
        int          lat, togg, rises, ss_low, cyc, pulses, p1, p2, hi_gap, falls, pv, tg;
        logic [4:0]  mask;
        logic [3:0]  msk, pss;
        logic [15:0] slots, rx;
        logic [7:0]  rx1, rx2;
        logic        prev;

        vt[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 4'b0001};
        vt[1] = '{1'b1, 1'b1, 1'b0, 3'd1, 8'hC3, 8'h3C, 1'b0, 8'h3C, 4'b0010};
        vt[2] = '{1'b0, 1'b1, 1'b1, 3'd3, 8'h5A, 8'h96, 1'b0, 8'h96, 4'b1000};
        vt[3] = '{1'b1, 1'b0, 1'b1, 3'd2, 8'h01, 8'h80, 1'b0, 8'h80, 4'b0100};

        rst_n = 1'b0; va = 1'b0; vb = 1'b0; mb = 1'b0; loop_a = 1'b1;
        d_cpol = 1'b0; d_cpha = 1'b0; d_lsb = 1'b0; d_sel = '0; d_tx = '0;
        s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_miso = 1'b0;
        s_selq = 1'b0; s_sckq = 1'b0; s_word = '0; s_rx = '0; s_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", ua_tx_ready, 1);
        chk("rst_sck", ua_sck, 0);
        chk("rst_mosi", ua_mosi, 0);
        chk("rst_ss_n", ua_ss_n, 4'hf);
        chk("rst_rx_data", ua_rx_data, 0);
        chk("rst_rx_valid", ua_rx_valid, 0);
        chk("rst_busy", ua_busy, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sck_after_release", ua_sck, 0);

        for (int i = 0; i < 4; i++) begin
            loop_a = vt[i].loop;
            s_word = vt[i].sw;
            xfer(1'b0, vt[i].cpol, vt[i].cpha, vt[i].lsb, vt[i].sel, {8'h00, vt[i].tx},
                 lat, togg, rises, ss_low, mask, slots, rx);
            chk($sformatf("v%0d_latency", i), lat, 72);
            chk($sformatf("v%0d_sck_toggles", i), togg, 16);
            chk($sformatf("v%0d_sck_rises", i), rises, 8);
            chk($sformatf("v%0d_ss_low_cycles", i), ss_low, 72);
            chk($sformatf("v%0d_ss_mask", i), mask, {1'b0, vt[i].exp_mask});
            chk($sformatf("v%0d_rx_data", i), rx, {8'h00, vt[i].exp_rx});
            chk($sformatf("v%0d_sck_idle", i), ua_sck, vt[i].cpol);
            if (!vt[i].loop) chk($sformatf("v%0d_slave_capture", i), s_rx, vt[i].tx);
            @(posedge clk); #1;
            chk($sformatf("v%0d_rx_valid_one_cycle", i), ua_rx_valid, 0);
            chk($sformatf("v%0d_mosi_idle", i), ua_mosi, 0);
        end

        // 16-bit LSB-first single-one word on instance B
        xfer(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0001, lat, togg, rises, ss_low, mask, slots, rx);
        chk("w16_latency", lat, 136);
        chk("w16_mosi_slots", slots, 16'h0001);
        chk("w16_rx_data", rx, 16'h0001);
        chk("w16_ss_low_cycles", ss_low, 136);
        chk("w16_ss_mask", mask, 5'b00001);

        // Out-of-range select on instance B
        xfer(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h1234, lat, togg, rises, ss_low, mask, slots, rx);
        chk("oor_ss_mask", mask, 5'b00000);
        chk("oor_sck_toggles", togg, 32);
        chk("oor_latency", lat, 136);
        chk("oor_rx_data", rx, 16'h1234);

        // Back-to-back transfers with tx_valid held high
        mb = 1'b0; loop_a = 1'b1;
        d_cpol = 1'b0; d_cpha = 1'b0; d_lsb = 1'b0; d_sel = 3'd2; d_tx = 16'h0096;
        va = 1'b1;
        @(posedge clk); #1;
        cyc = 0; pulses = 0; p1 = 0; p2 = 0; hi_gap = 0; falls = 1;
        msk = ~ua_ss_n; pss = ua_ss_n; rx1 = '0; rx2 = '0;
        while (cyc < 400 && pulses < 2) begin
            @(posedge clk); #1;
            cyc++;
            if (ua_rx_valid) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = cyc; rx1 = ua_rx_data;
                end else begin
                    p2 = cyc; rx2 = ua_rx_data; va = 1'b0;
                end
            end
            if (ua_ss_n == 4'hf && pulses == 1) hi_gap++;
            if (ua_ss_n != 4'hf && pss == 4'hf) falls++;
            msk |= ~ua_ss_n;
            pss = ua_ss_n;
        end
        chk("b2b_first_done", p1, 72);
        chk("b2b_second_done", p2, 145);
        chk("b2b_ss_high_gap", hi_gap, 1);
        chk("b2b_ss_falls", falls, 2);
        chk("b2b_ss_mask", msk, 4'b0100);
        chk("b2b_rx_first", rx1, 8'h96);
        chk("b2b_rx_second", rx2, 8'h96);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_no_queue_busy", ua_busy, 0);

        // Reset on the 5th sck edge
        d_cpol = 1'b0; d_cpha = 1'b0; d_lsb = 1'b0; d_sel = 3'd1; d_tx = 16'h005A;
        va = 1'b1;
        @(posedge clk); #1;
        va = 1'b0;
        tg = 0; cyc = 0; prev = ua_sck;
        while (cyc < 200 && tg < 5) begin
            @(posedge clk); #1;
            cyc++;
            if (ua_sck != prev) tg++;
            prev = ua_sck;
        end
        chk("rst5_edge_reached", tg, 5);
        rst_n = 1'b0;
        #1;
        chk("rst5_ss_n", ua_ss_n, 4'hf);
        chk("rst5_sck", ua_sck, 0);
        chk("rst5_busy", ua_busy, 0);
        chk("rst5_tx_ready", ua_tx_ready, 1);
        chk("rst5_mosi", ua_mosi, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pv = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (ua_rx_valid) pv++;
        end
        chk("rst5_no_rx_valid", pv, 0);
        chk("rst5_rx_data_cleared", ua_rx_data, 0);
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h003C, lat, togg, rises, ss_low, mask, slots, rx);
        chk("rst5_next_latency", lat, 72);
        chk("rst5_next_rx", rx, 16'h003C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
